// File: rtl/eth_txbackoff_ctrl.sv
// Half/full duplex transmit scheduler: inter-packet gap, collision retry counting
// and truncated binary exponential backoff driven by a free-running 10-bit LFSR.
module eth_txbackoff_ctrl #(
    parameter int unsigned SLOT_NIBBLES = 128,
    parameter logic [9:0]  LFSR_SEED    = 10'h3FF
) (
    input  logic       MTxClk,
    input  logic       Reset,
    input  logic       TxReq,
    input  logic       TxDoneIn,
    input  logic       CollisionIn,
    input  logic       CarrierSense,
    input  logic       FullD,
    input  logic       NoBckof,
    input  logic [3:0] MaxRet,
    input  logic [6:0] IPGT,
    output logic       TxStart,
    output logic       TxOk,
    output logic       TxAbort,
    output logic [3:0] RetryCnt,
    output logic       Busy,
    output logic       InBackoff
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IPG     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

    localparam logic [6:0] NIB_LAST = 7'(SLOT_NIBBLES - 1);

    state_t     state_r, state_s;
    logic [6:0] ipg_cnt_r, ipg_cnt_s;
    logic [6:0] nib_cnt_r, nib_cnt_s;
    logic [9:0] slot_cnt_r, slot_cnt_s;
    logic [3:0] retry_r, retry_s;
    logic [9:0] lfsr_r, lfsr_s;
    logic       tx_start_r, tx_start_s;
    logic       tx_ok_r, tx_ok_s;
    logic       tx_abort_r, tx_abort_s;
    logic       busy_r, busy_s;
    logic       in_backoff_r, in_backoff_s;
    logic [6:0] ipg_last_s;
    logic       carrier_block_s;
    logic [3:0] retry_inc_s;

    // Backoff window mask 2^k-1, with k saturating at 10 retries.
    function automatic logic [9:0] backoff_mask(input logic [3:0] retry);
        logic [9:0] mask;
        if (retry >= 4'd10) begin
            mask = 10'h3FF;
        end else begin
            mask = (10'd1 << retry) - 10'd1;
        end
        return mask;
    endfunction

    // Next-state, counter and output decode.
    always_comb begin
        state_s         = state_r;
        ipg_cnt_s       = ipg_cnt_r;
        nib_cnt_s       = nib_cnt_r;
        slot_cnt_s      = slot_cnt_r;
        retry_s         = retry_r;
        lfsr_s          = {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
        tx_start_s      = 1'b0;
        tx_ok_s         = 1'b0;
        tx_abort_s      = 1'b0;
        ipg_last_s      = (IPGT == 7'd0) ? 7'd0 : (IPGT - 7'd1);
        carrier_block_s = CarrierSense & ~FullD;
        retry_inc_s     = retry_r + 4'd1;

        case (state_r)
            ST_IDLE: begin
                if (TxReq && !carrier_block_s) begin
                    state_s   = ST_IPG;
                    retry_s   = 4'd0;
                    ipg_cnt_s = 7'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_IPG: begin
                // A sensed carrier restarts the gap; >= tolerates IPGT shrinking mid-count.
                if (carrier_block_s) begin
                    ipg_cnt_s = 7'd0;
                end else if (ipg_cnt_r >= ipg_last_s) begin
                    tx_start_s = 1'b1;
                    ipg_cnt_s  = 7'd0;
                    state_s    = ST_ACTIVE;
                end else begin
                    ipg_cnt_s = ipg_cnt_r + 7'd1;
                end
            end
            ST_ACTIVE: begin
                if (CollisionIn) begin
                    if (retry_r >= MaxRet) begin
                        tx_abort_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        retry_s    = retry_inc_s;
                        slot_cnt_s = NoBckof ? 10'd0 : (lfsr_r & backoff_mask(retry_inc_s));
                        nib_cnt_s  = 7'd0;
                        state_s    = ST_BACKOFF;
                    end
                end else if (TxDoneIn) begin
                    tx_ok_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_BACKOFF: begin
                if (slot_cnt_r == 10'd0) begin
                    ipg_cnt_s = 7'd0;
                    state_s   = ST_IPG;
                end else if (nib_cnt_r == NIB_LAST) begin
                    nib_cnt_s  = 7'd0;
                    slot_cnt_s = slot_cnt_r - 10'd1;
                    if (slot_cnt_r == 10'd1) begin
                        ipg_cnt_s = 7'd0;
                        state_s   = ST_IPG;
                    end else begin
                        state_s = ST_BACKOFF;
                    end
                end else begin
                    nib_cnt_s = nib_cnt_r + 7'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s       = (state_s != ST_IDLE);
        in_backoff_s = (state_s == ST_BACKOFF);
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge MTxClk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            ipg_cnt_r    <= 7'd0;
            nib_cnt_r    <= 7'd0;
            slot_cnt_r   <= 10'd0;
            retry_r      <= 4'd0;
            lfsr_r       <= LFSR_SEED;
            tx_start_r   <= 1'b0;
            tx_ok_r      <= 1'b0;
            tx_abort_r   <= 1'b0;
            busy_r       <= 1'b0;
            in_backoff_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            ipg_cnt_r    <= ipg_cnt_s;
            nib_cnt_r    <= nib_cnt_s;
            slot_cnt_r   <= slot_cnt_s;
            retry_r      <= retry_s;
            lfsr_r       <= lfsr_s;
            tx_start_r   <= tx_start_s;
            tx_ok_r      <= tx_ok_s;
            tx_abort_r   <= tx_abort_s;
            busy_r       <= busy_s;
            in_backoff_r <= in_backoff_s;
        end
    end

    assign TxStart   = tx_start_r;
    assign TxOk      = tx_ok_r;
    assign TxAbort   = tx_abort_r;
    assign RetryCnt  = retry_r;
    assign Busy      = busy_r;
    assign InBackoff = in_backoff_r;

endmodule

// File: tb/tb_eth_txbackoff_ctrl.sv
// Bench for eth_txbackoff_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a duration-based behavioural model.
module tb_eth_txbackoff_ctrl;

    localparam int SLOT = 128;
    localparam int SEED = 10'h3FF;

    localparam int M_IDLE = 0;
    localparam int M_GAP  = 1;
    localparam int M_TX   = 2;
    localparam int M_WAIT = 3;

    logic       MTxClk = 1'b0;
    logic       Reset, TxReq, TxDoneIn, CollisionIn, CarrierSense, FullD, NoBckof;
    logic [3:0] MaxRet;
    logic [6:0] IPGT;
    logic       TxStart, TxOk, TxAbort, Busy, InBackoff;
    logic [3:0] RetryCnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: phase, clear-carrier run, remaining backoff cycles, retries
    int m_phase, m_run, m_left, m_retry, m_last_r;
    bit m_start, m_ok, m_abort;
    bit seq[$];

    always #5 MTxClk = ~MTxClk;

    eth_txbackoff_ctrl dut (
        .MTxClk(MTxClk), .Reset(Reset), .TxReq(TxReq), .TxDoneIn(TxDoneIn),
        .CollisionIn(CollisionIn), .CarrierSense(CarrierSense), .FullD(FullD),
        .NoBckof(NoBckof), .MaxRet(MaxRet), .IPGT(IPGT), .TxStart(TxStart),
        .TxOk(TxOk), .TxAbort(TxAbort), .RetryCnt(RetryCnt), .Busy(Busy),
        .InBackoff(InBackoff)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // bit sequence, newest first; register value = sum of seq[i] << i
    task automatic seed_seq();
        seq = {};
        for (int i = 0; i < 10; i++) seq.push_back(bit'((SEED >> i) & 1));
    endtask

    function automatic int seq_value();
        int v = 0;
        for (int i = 0; i < 10; i++) v = v | (int'(seq[i]) << i);
        return v;
    endfunction

    task automatic model_step();
        int  cur, need, k, r;
        bit  blocked;
        cur     = seq_value();
        m_start = 1'b0;
        m_ok    = 1'b0;
        m_abort = 1'b0;
        if (Reset) begin
            m_phase = M_IDLE; m_run = 0; m_left = 0; m_retry = 0;
            seed_seq();
        end else begin
            seq.push_front(seq[9] ^ seq[6]);
            void'(seq.pop_back());
            blocked = CarrierSense && !FullD;
            need    = (IPGT == 7'd0) ? 1 : int'(IPGT);
            case (m_phase)
                M_IDLE: if (TxReq && !blocked) begin
                    m_phase = M_GAP; m_run = 0; m_retry = 0;
                end
                M_GAP: if (blocked) m_run = 0;
                       else if (m_run + 1 >= need) begin m_start = 1'b1; m_phase = M_TX; end
                       else m_run++;
                M_TX: if (CollisionIn) begin
                    if (m_retry >= int'(MaxRet)) begin
                        m_abort = 1'b1; m_phase = M_IDLE;
                    end else begin
                        m_retry++;
                        k = (m_retry < 10) ? m_retry : 10;
                        r = NoBckof ? 0 : (cur & ((1 << k) - 1));
                        m_last_r = r;
                        m_left   = (r == 0) ? 1 : r * SLOT;
                        m_phase  = M_WAIT;
                    end
                end else if (TxDoneIn) begin
                    m_ok = 1'b1; m_phase = M_IDLE;
                end
                M_WAIT: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = M_GAP; m_run = 0; end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge MTxClk);
        model_step();
        #1;
        check_eq("TxStart",   int'(TxStart),   int'(m_start));
        check_eq("TxOk",      int'(TxOk),      int'(m_ok));
        check_eq("TxAbort",   int'(TxAbort),   int'(m_abort));
        check_eq("Busy",      int'(Busy),      int'(m_phase != M_IDLE));
        check_eq("InBackoff", int'(InBackoff), int'(m_phase == M_WAIT));
        check_eq("RetryCnt",  int'(RetryCnt),  m_retry);
    endtask

    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        while (!TxStart && lat < 3000) begin tick(); lat++; end
        check_eq({tag, "_seen"}, int'(TxStart), 1);
    endtask

    task automatic wait_busy(input string tag);
        int b = 0;
        while (!Busy && b < 20) begin tick(); b++; end
        check_eq({tag, "_busy"}, int'(Busy), 1);
    endtask

    task automatic pulse_done();
        TxDoneIn = 1'b1; tick(); TxDoneIn = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; tick(); tick(); Reset = 1'b0;
    endtask

    initial begin
        int lat, starts, dur, exp_dur;
        bit aborted;
        Reset = 1'b1; TxReq = 1'b0; TxDoneIn = 1'b0; CollisionIn = 1'b0;
        CarrierSense = 1'b0; FullD = 1'b1; NoBckof = 1'b0; MaxRet = 4'd15; IPGT = 7'd12;
        m_phase = M_IDLE; m_run = 0; m_left = 0; m_retry = 0; m_last_r = 0;
        seed_seq();
        do_reset();
        check_eq("rst_busy", int'(Busy), 0);
        check_eq("rst_retry", int'(RetryCnt), 0);

        // full duplex gap of 12, then a clean completion
        TxReq = 1'b1;
        wait_busy("s041");
        TxReq = 1'b0;
        wait_start("s041", lat);
        check_eq("s041_start_lat", lat, 12);
        repeat (49) tick();
        pulse_done();
        check_eq("s041_ok", int'(TxOk), 1);
        check_eq("s041_retry", int'(RetryCnt), 0);
        tick();

        // half duplex deferral: carrier during the gap restarts it
        FullD = 1'b0; TxReq = 1'b1;
        wait_busy("s042");
        TxReq = 1'b0;
        repeat (5) tick();
        CarrierSense = 1'b1;
        repeat (16) tick();
        CarrierSense = 1'b0;
        wait_start("s042", lat);
        check_eq("s042_start_lat", lat, 12);
        pulse_done();
        tick();

        // no backoff, MaxRet=2: two retries then abort
        FullD = 1'b1; IPGT = 7'd1; NoBckof = 1'b1; MaxRet = 4'd2; TxReq = 1'b1;
        starts = 0; aborted = 1'b0;
        for (int a = 0; a < 4 && !aborted; a++) begin
            wait_start("s043", lat);
            TxReq = 1'b0;
            starts++;
            CollisionIn = 1'b1; tick(); CollisionIn = 1'b0;
            if (TxAbort) aborted = 1'b1;
            else check_eq("s043_retry", int'(RetryCnt), starts);
        end
        check_eq("s043_starts", starts, 3);
        check_eq("s043_aborted", int'(aborted), 1);
        check_eq("s043_final_retry", int'(RetryCnt), 2);
        tick();

        // one collision from the reset seed: backoff length from the model LFSR
        do_reset();
        NoBckof = 1'b0; MaxRet = 4'd15; TxReq = 1'b1;
        wait_start("s044", lat);
        TxReq = 1'b0;
        CollisionIn = 1'b1; tick(); CollisionIn = 1'b0;
        check_eq("s044_r_range", int'(m_last_r <= 1), 1);
        exp_dur = (m_last_r == 0) ? 1 : m_last_r * SLOT;
        dur = 0;
        while (InBackoff && dur < 2000) begin dur++; tick(); end
        check_eq("s044_backoff_len", dur, exp_dur);
        wait_start("s044b", lat);
        pulse_done();
        tick();

        // simultaneous done and collision: collision wins, then reset in backoff
        TxReq = 1'b1;
        wait_start("s045", lat);
        TxReq = 1'b0;
        TxDoneIn = 1'b1; CollisionIn = 1'b1; tick();
        TxDoneIn = 1'b0; CollisionIn = 1'b0;
        check_eq("s045_backoff", int'(InBackoff), 1);
        check_eq("s045_retry", int'(RetryCnt), 1);
        check_eq("s045_no_ok", int'(TxOk), 0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        check_eq("s046_busy", int'(Busy), 0);
        check_eq("s046_retry", int'(RetryCnt), 0);
        check_eq("s046_backoff", int'(InBackoff), 0);
        repeat (10) tick();

        // random traffic against the model
        for (int c = 0; c < 15000; c++) begin
            if (c % 500 == 0) begin
                FullD   = 1'($urandom_range(0, 1));
                IPGT    = 7'($urandom_range(0, 20));
                MaxRet  = 4'($urandom_range(0, 3));
                NoBckof = ($urandom_range(0, 3) == 0);
            end
            Reset       = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 99) < 3) TxReq = ~TxReq;
            if ($urandom_range(0, 19) == 0) CarrierSense = ~CarrierSense;
            TxDoneIn    = ($urandom_range(0, 39) == 0);
            CollisionIn = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
